// File: rtl/rf_write_port_arbiter.sv
// rf_write_port_arbiter
//   Owns the single register-file write port (A3/WD3/WE3). The WB stage is
//   the primary writer. Long-latency unit (LU) results queue in a small FIFO
//   and take the port whenever WB is idle, or forcibly once WB has starved
//   them for STARVE_LIMIT consecutive cycles. A 32-bit pending scoreboard
//   tracks LU destinations that are issued but not yet written back. Decode
//   stalls on any read of, or re-issue to, a pending register.
//
// Ports
//   CLK, RST              clock, async active-low reset
//   wb_we/wb_addr/wb_data WB write request (writes to r0 are dropped)
//   lu_valid/addr/data    LU result; lu_ready = FIFO not full
//   iss_valid/iss_addr    LU op issued at decode (sets the pending bit)
//   rd_a1, rd_a2          decode read addresses
//   hazard_stall          decode must stall (RAW on a pending reg, or WAW)
//   pipe_stall            WB lost the port this cycle and must hold
//   rf_we/rf_a3/rf_wd     register file write port, same-cycle grant
//   pending_mask          scoreboard, bit r = LU write to r outstanding
//
// Optional feature (define RF_WRITE_BYPASS_EN)
//   byp{1,2}_hit/data forward the write in flight to the decode read ports.

module rf_write_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int WIDTH        = 32,
  parameter int REG_ADDR     = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wb_we,
  input  logic [REG_ADDR-1:0] wb_addr,
  input  logic [WIDTH-1:0]    wb_data,
  input  logic                lu_valid,
  input  logic [REG_ADDR-1:0] lu_addr,
  input  logic [WIDTH-1:0]    lu_data,
  output logic                lu_ready,
  input  logic                iss_valid,
  input  logic [REG_ADDR-1:0] iss_addr,
  input  logic [REG_ADDR-1:0] rd_a1,
  input  logic [REG_ADDR-1:0] rd_a2,
  output logic                hazard_stall,
  output logic                pipe_stall,
  output logic                rf_we,
  output logic [REG_ADDR-1:0] rf_a3,
  output logic [WIDTH-1:0]    rf_wd,
  output logic [31:0]         pending_mask
`ifdef RF_WRITE_BYPASS_EN
  ,
  output logic                byp1_hit,
  output logic [WIDTH-1:0]    byp1_data,
  output logic                byp2_hit,
  output logic [WIDTH-1:0]    byp2_data
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] ST_ONE   = SW'(1);
  localparam logic [SW-1:0] ST_LIM   = SW'(STARVE_LIMIT);

  // LU write buffer
  logic [REG_ADDR-1:0] fa_q [FIFO_DEPTH];
  logic [WIDTH-1:0]    fd_q [FIFO_DEPTH];
  logic [PW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [31:0]         pend_q, pend_d;

  logic empty, full, push, pop, force_lu, wb_req, wb_gnt, issue_eff;
  logic [REG_ADDR-1:0] head_a;
  logic [WIDTH-1:0]    head_d;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_FULL);
  assign head_a = fa_q[rp_q];
  assign head_d = fd_q[rp_q];

  // Ready comes from registered occupancy only; a same-cycle pop does not
  // reopen it, which keeps lu_ready free of any path through the grant.
  assign lu_ready = !full;
  assign push     = lu_valid & lu_ready;

  assign wb_req   = wb_we & (wb_addr != '0);
  assign force_lu = (starve_q == ST_LIM) & !empty;
  assign pop      = !empty & (force_lu | !wb_req);
  assign wb_gnt   = wb_req & !force_lu;

  // RST gates the port so nothing reaches the register file while held.
  always_comb begin
    rf_we      = 1'b0;
    rf_a3      = '0;
    rf_wd      = '0;
    pipe_stall = RST & wb_req & force_lu;
    if (RST) begin
      if (pop) begin
        // an r0 result is drained from the FIFO without writing
        if (head_a != '0) begin
          rf_we = 1'b1;
          rf_a3 = head_a;
          rf_wd = head_d;
        end
      end else if (wb_gnt) begin
        rf_we = 1'b1;
        rf_a3 = wb_addr;
        rf_wd = wb_data;
      end
    end
  end

  // pend_q[0] is never set, so address-0 terms drop out on their own; the
  // explicit compares keep that true even if the scoreboard ever changes.
  assign hazard_stall = ((rd_a1 != '0) & pend_q[rd_a1])
                      | ((rd_a2 != '0) & pend_q[rd_a2])
                      | (iss_valid & (iss_addr != '0) & pend_q[iss_addr]);

  assign issue_eff    = iss_valid & !hazard_stall & (iss_addr != '0);
  assign pending_mask = pend_q;

  always_comb begin
    wp_d     = push ? wp_q + PTR_ONE : wp_q;
    rp_d     = pop  ? rp_q + PTR_ONE : rp_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_ONE;
    if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    starve_d = starve_q;
    if (empty || pop)          starve_d = '0;
    else if (starve_q < ST_LIM) starve_d = starve_q + ST_ONE;
    // clear first so a same-cycle set of the same bit wins
    pend_d = pend_q;
    if (pop)       pend_d[head_a]   = 1'b0;
    if (issue_eff) pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge CLK) begin
    if (push) begin
      fa_q[wp_q] <= lu_addr;
      fd_q[wp_q] <= lu_data;
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  assign byp1_hit  = rf_we & (rf_a3 == rd_a1) & (rd_a1 != '0);
  assign byp2_hit  = rf_we & (rf_a3 == rd_a2) & (rd_a2 != '0);
  assign byp1_data = rf_wd;
  assign byp2_data = rf_wd;
`endif

endmodule
